// File: rtl/gf_mul_ds.sv
`default_nettype none
// gf_mul_ds: digit-serial GF(2^WIDTH) multiplier/accumulator (Horner, MSB-first digits of b).
// Revision 1.0
module gf_mul_ds #(
    parameter int               WIDTH = 128,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'('h87),
    parameter int               DIGIT = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             acc_en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] z_o
);

    localparam int NCYC = WIDTH / DIGIT;
    localparam int CW   = $clog2(NCYC + 1);

    generate
        if (WIDTH < 8 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("gf_mul_ds: illegal WIDTH/DIGIT combination");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] w_q, w_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             acc_q, acc_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] w_next;

    // One Horner step per bit of the top digit, unrolled within the cycle.
    always_comb begin
        logic [WIDTH-1:0] w_tmp;
        w_tmp = w_q;
        for (int k = DIGIT - 1; k >= 0; k--) begin
            w_tmp = {w_tmp[WIDTH-2:0], 1'b0}
                  ^ (w_tmp[WIDTH-1] ? POLY : '0)
                  ^ (b_q[WIDTH-DIGIT+k] ? a_q : '0);
        end
        w_next = w_tmp;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        w_d     = w_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clr_i) begin
                    z_d = '0;
                end
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    acc_d   = acc_en_i;
                    w_d     = '0;
                    cnt_d   = CW'(NCYC);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                w_d   = w_next;
                b_d   = b_q << DIGIT;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    // Accumulation uses the z seen at completion, so a clr+start pair yields a*b.
                    z_d     = acc_q ? (z_q ^ w_next) : w_next;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            w_q     <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            w_q     <= w_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q == S_RUN);
    assign done_o = done_q;
    assign z_o    = z_q;

endmodule
`default_nettype wire

// File: tb/tb_gf_mul_ds.sv
`default_nettype none
// tb_gf_mul_ds: directed and swept checks of gf_mul_ds in several configurations.
// Revision 1.0
module tb_gf_mul_ds;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         acc_en = 1'b0;
    logic         clr = 1'b0;
    logic [63:0]  a64 = '0;
    logic [63:0]  b64 = '0;
    logic [127:0] a128 = '0;
    logic [127:0] b128 = '0;

    logic         busy4, done4, busy1, done1, busy8, done8, busy128, done128;
    logic [63:0]  z4, z1, z8;
    logic [127:0] z128;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gf_mul_ds #(.WIDTH(64), .POLY(64'h1B), .DIGIT(4)) u_d4 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .acc_en_i(acc_en), .clr_i(clr),
        .a_i(a64), .b_i(b64), .busy_o(busy4), .done_o(done4), .z_o(z4));
    gf_mul_ds #(.WIDTH(64), .POLY(64'h1B), .DIGIT(1)) u_d1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .acc_en_i(acc_en), .clr_i(clr),
        .a_i(a64), .b_i(b64), .busy_o(busy1), .done_o(done1), .z_o(z1));
    gf_mul_ds #(.WIDTH(64), .POLY(64'h1B), .DIGIT(8)) u_d8 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .acc_en_i(acc_en), .clr_i(clr),
        .a_i(a64), .b_i(b64), .busy_o(busy8), .done_o(done8), .z_o(z8));
    gf_mul_ds #(.WIDTH(128), .POLY(128'h87), .DIGIT(4)) u_w128 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .acc_en_i(acc_en), .clr_i(clr),
        .a_i(a128), .b_i(b128), .busy_o(busy128), .done_o(done128), .z_o(z128));

    // Reference: LSB-first shift-and-add with xtime on a.
    function automatic logic [63:0] ref64(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r, x;
        r = '0;
        x = a;
        for (int i = 0; i < 64; i++) begin
            if (b[i]) r = r ^ x;
            x = x[63] ? ((x << 1) ^ 64'h1B) : (x << 1);
        end
        return r;
    endfunction

    function automatic logic [127:0] ref128(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] r, x;
        r = '0;
        x = a;
        for (int i = 0; i < 128; i++) begin
            if (b[i]) r = r ^ x;
            x = x[127] ? ((x << 1) ^ 128'h87) : (x << 1);
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one op and waits (bounded) for done4; lat = edges from start edge to done.
    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic acc,
                         input int clr_mid, output int lat);
        a64 = a; b64 = b; acc_en = acc; start = 1'b1;
        step();
        start = 1'b0;
        clr = 1'b0;
        lat = 0;
        while (done4 !== 1'b1 && lat < 40) begin
            step();
            lat++;
            clr = (lat == clr_mid);
        end
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        total++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || z4 !== 64'h0) begin
            bad++;
            $display("FAIL reset_d4 busy=%b done=%b z=%h required 0 0 0", busy4, done4, z4);
        end
        total++;
        if (busy128 !== 1'b0 || done128 !== 1'b0 || z128 !== 128'h0) begin
            bad++;
            $display("FAIL reset_w128 busy=%b done=%b z=%h required 0 0 0", busy128, done128, z128);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int lat;
        do_op(64'h1, 64'h0123_4567_89AB_CDEF, 1'b0, 0, lat);
        total++;
        if (lat !== 16) begin
            bad++; $display("FAIL basic_latency got=%0d required=16", lat);
        end
        total++;
        if (z4 !== 64'h0123_4567_89AB_CDEF) begin
            bad++; $display("FAIL basic_z got=%h required=0123456789abcdef", z4);
        end
        step();
        total++;
        if (done4 !== 1'b0 || busy4 !== 1'b0) begin
            bad++; $display("FAIL basic_done_pulse done=%b busy=%b required 0 0", done4, busy4);
        end
    endtask

    task automatic test_reduction();
        int lat;
        do_op(64'h8000_0000_0000_0000, 64'h2, 1'b0, 0, lat);
        total++;
        if (z4 !== 64'h1B) begin
            bad++; $display("FAIL reduce_x64 got=%h required=000000000000001b", z4);
        end
        do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 0, lat);
        total++;
        if (z4 !== 64'hC000_0000_0000_005A) begin
            bad++; $display("FAIL reduce_x126 got=%h required=c00000000000005a", z4);
        end
    endtask

    task automatic test_accumulate();
        int lat;
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        total++;
        if (z4 !== 64'h0 || done4 !== 1'b0) begin
            bad++; $display("FAIL acc_clr z=%h done=%b required 0 0", z4, done4);
        end
        do_op(64'h1, 64'h5, 1'b1, 0, lat);
        total++;
        if (z4 !== 64'h5) begin
            bad++; $display("FAIL acc_first got=%h required=5", z4);
        end
        // A clr pulse while busy must not disturb the accumulator.
        do_op(64'h1, 64'h3, 1'b1, 5, lat);
        total++;
        if (z4 !== 64'h6) begin
            bad++; $display("FAIL acc_second got=%h required=6", z4);
        end
        do_op(64'h1, 64'h3, 1'b0, 0, lat);
        total++;
        if (z4 !== 64'h3) begin
            bad++; $display("FAIL acc_overwrite got=%h required=3", z4);
        end
        clr = 1'b1;
        do_op(64'h1, 64'h6, 1'b1, 0, lat);
        total++;
        if (z4 !== 64'h6) begin
            bad++; $display("FAIL acc_clr_with_start got=%h required=6", z4);
        end
    endtask

    task automatic test_protocol();
        int ndone = 0;
        int first = 0;
        a64 = 64'h3; b64 = 64'h5; acc_en = 1'b0; start = 1'b1;
        step();
        for (int c = 1; c <= 30; c++) begin
            start = (c == 3 || c == 8);
            if (c >= 2 && c <= 10) begin
                a64 = {$urandom, $urandom};
                b64 = {$urandom, $urandom};
            end
            acc_en = (c % 2 == 1);
            step();
            if (done4 === 1'b1) begin
                ndone++;
                if (first == 0) first = c;
            end
        end
        start = 1'b0; acc_en = 1'b0;
        total++;
        if (ndone !== 1 || first !== 16) begin
            bad++; $display("FAIL protocol_done count=%0d at=%0d required count=1 at=16", ndone, first);
        end
        total++;
        if (z4 !== 64'hF) begin
            bad++; $display("FAIL protocol_z got=%h required=f", z4);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int n;
        do_op(64'h1, 64'h7, 1'b0, 0, lat);
        total++;
        if (lat !== 16 || z4 !== 64'h7) begin
            bad++; $display("FAIL b2b_first lat=%0d z=%h required lat=16 z=7", lat, z4);
        end
        a64 = 64'h1; b64 = 64'h9; start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        while (done4 !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        total++;
        if (n !== 17 || z4 !== 64'h9) begin
            bad++; $display("FAIL b2b_second gap=%0d z=%h required gap=17 z=9", n, z4);
        end
    endtask

    task automatic test_async_reset();
        int lat;
        a64 = 64'h0123_4567_89AB_CDEF; b64 = 64'hFFFF_0000_1234_5678; acc_en = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || z4 !== 64'h0) begin
            bad++; $display("FAIL async_reset busy=%b done=%b z=%h required 0 0 0", busy4, done4, z4);
        end
        #2;
        rst_n = 1'b1;
        step();
        do_op(64'h8000_0000_0000_0000, 64'h2, 1'b0, 0, lat);
        total++;
        if (lat !== 16 || z4 !== 64'h1B) begin
            bad++; $display("FAIL after_reset lat=%0d z=%h required lat=16 z=1b", lat, z4);
        end
    endtask

    task automatic test_latency_sweep();
        int bc1 = 0, bc4 = 0, bc8 = 0, bc128 = 0;
        int dn1 = 0, dn4 = 0, dn8 = 0, dn128 = 0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        a64 = 64'hDEAD_BEEF_0BAD_F00D; b64 = 64'h1357_9BDF_2468_ACE0;
        a128 = {a64, b64}; b128 = {b64, a64};
        acc_en = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int e = 1; e <= 70; e++) begin
            if (busy1)   bc1++;
            if (busy4)   bc4++;
            if (busy8)   bc8++;
            if (busy128) bc128++;
            step();
            if (done1   === 1'b1 && dn1   == 0) dn1   = e;
            if (done4   === 1'b1 && dn4   == 0) dn4   = e;
            if (done8   === 1'b1 && dn8   == 0) dn8   = e;
            if (done128 === 1'b1 && dn128 == 0) dn128 = e;
        end
        total++;
        if (dn1 !== 64 || bc1 !== 64) begin
            bad++; $display("FAIL lat_d1 done_at=%0d busy=%0d required 64 64", dn1, bc1);
        end
        total++;
        if (dn4 !== 16 || bc4 !== 16) begin
            bad++; $display("FAIL lat_d4 done_at=%0d busy=%0d required 16 16", dn4, bc4);
        end
        total++;
        if (dn8 !== 8 || bc8 !== 8) begin
            bad++; $display("FAIL lat_d8 done_at=%0d busy=%0d required 8 8", dn8, bc8);
        end
        total++;
        if (dn128 !== 32 || bc128 !== 32) begin
            bad++; $display("FAIL lat_w128 done_at=%0d busy=%0d required 32 32", dn128, bc128);
        end
        for (int v = 0; v < 60; v++) begin
            logic [63:0]  e64;
            logic [127:0] e128;
            a64  = {$urandom, $urandom};
            b64  = {$urandom, $urandom};
            a128 = {$urandom, $urandom, $urandom, $urandom};
            b128 = {$urandom, $urandom, $urandom, $urandom};
            e64  = ref64(a64, b64);
            e128 = ref128(a128, b128);
            start = 1'b1;
            step();
            start = 1'b0;
            repeat (66) step();
            total++;
            if (z1 !== e64 || z4 !== e64 || z8 !== e64) begin
                bad++; $display("FAIL rand64 v=%0d z1=%h z4=%h z8=%h required=%h", v, z1, z4, z8, e64);
            end
            total++;
            if (z128 !== e128) begin
                bad++; $display("FAIL rand128 v=%0d got=%h required=%h", v, z128, e128);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reduction();
        test_accumulate();
        test_protocol();
        test_back_to_back();
        test_async_reset();
        test_latency_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
